pwm_duty_decoder: RTL and testbench
===================================

PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

Interface
REQ-001 Parameter CNT_WIDTH, default 16, SHALL set the width of all measurement counters and outputs.
REQ-002 Parameter TIMEOUT, default 65535, SHALL set the no-edge cycle limit; legal range 2..2^CNT_WIDTH-1.
REQ-003 Port clk, input, 1 bit: clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port pwm_in, input, 1 bit: PWM waveform under measurement, asynchronous to clk.
REQ-006 Port period, output, CNT_WIDTH bits: last measured period in clk cycles, rising edge to rising edge.
REQ-007 Port high_time, output, CNT_WIDTH bits: last measured high time in clk cycles, rising edge to falling edge.
REQ-008 Port valid, output, 1 bit: single-cycle pulse when period/high_time are updated.
REQ-009 Port timeout, output, 1 bit: level, no edge seen for TIMEOUT cycles.
REQ-010 Port level, output, 1 bit: synchronized pwm_in level.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer; a third flop SHALL hold the previous synchronized level for edge detection.
REQ-012 rise = sync & ~prev and fall = ~sync & prev SHALL be evaluated each cycle; level SHALL equal sync.
REQ-013 FSM states SHALL be IDLE, MEAS_HIGH and MEAS_LOW.
REQ-014 IDLE: on rise go to MEAS_HIGH and load cnt=1; fall is ignored.
REQ-015 MEAS_HIGH: on fall, capture hi_tmp=cnt, set cnt=cnt+1 and go to MEAS_LOW; otherwise cnt=cnt+1.
REQ-016 MEAS_LOW: on rise, load period=cnt and high_time=hi_tmp, pulse valid for exactly one cycle, load cnt=1 and go to MEAS_HIGH; otherwise cnt=cnt+1.
REQ-017 valid, period and high_time SHALL update on the clk edge that closes the rise-detection cycle (output registered, 1 cycle after rise is asserted).
REQ-018 End-to-end latency: a pwm_in rising edge set up before clk edge k SHALL produce valid high during cycle k+3.
REQ-019 Measurement semantics: rise detections at cycles t0 and t2 with fall detection at t1 SHALL give period=t2-t0 and high_time=t1-t0.
REQ-020 In MEAS_HIGH or MEAS_LOW, when cnt reaches TIMEOUT with no qualifying edge in that cycle, the FSM SHALL go to IDLE, assert timeout, and leave period/high_time unchanged.
REQ-021 timeout SHALL clear on the next rise detection, in the same cycle the FSM enters MEAS_HIGH.
REQ-022 cnt SHALL never wrap; TIMEOUT fires at or before 2^CNT_WIDTH-1.
REQ-023 An edge in the same cycle cnt reaches TIMEOUT SHALL take priority: normal transition, no timeout.
REQ-024 A 1-cycle high pulse SHALL measure high_time=1; a 1-cycle low gap SHALL measure period=high_time+1.
REQ-025 period and high_time SHALL hold their last values between valid pulses.
REQ-026 The first valid after reset or timeout SHALL require a full period, rise to rise; a partial first high phase is never reported.

Reset
REQ-027 On rst: FSM=IDLE, cnt=0, hi_tmp=0, period=0, high_time=0, valid=0, timeout=0, synchronizer and prev flops=0, level=0.
REQ-028 rst asserted mid-measurement SHALL discard the partial measurement; no valid is produced for that period.

Verification
REQ-029 Clk-synchronous pwm_in, period 2046, high 245, 4 periods -> 3 valid pulses, each with period=2046 and high_time=245.
REQ-030 Duty sweep high=1, 1023, 2045 at period 2046 -> high_time equals the programmed high, period=2046, valid once per period.
REQ-031 TIMEOUT=100, pwm_in held high after one rise -> timeout=1 at cycle 100 after rise, FSM IDLE, period/high_time unchanged; next rise clears timeout.
REQ-032 rst pulsed mid-high-phase, then period 50/high 20 -> all outputs 0 during rst, first valid only after a full post-reset period, values 50/20.
REQ-033 Edge coincident with cnt==TIMEOUT (period=TIMEOUT) -> valid with period=TIMEOUT, timeout stays 0.
REQ-034 pwm_in edges offset asynchronously (random sub-cycle phase) -> measured period within ±1 of nominal, never wrap, no spurious valid.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// PWM period / high-time decoder: synchronizes pwm_in, detects edges and counts
// clk cycles rise-to-fall and rise-to-rise, with a no-edge timeout.
`timescale 1ns/1ps

module pwm_duty_decoder #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 timeout,
    output logic                 level
);

    typedef enum logic [1:0] {
        IDLE,
        MEAS_HIGH,
        MEAS_LOW
    } state_e;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [1:0]           prime_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] hiTmp_q, hiTmp_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] highTime_q, highTime_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;
    logic                 primed, rise, fall, atLimit;
    logic [CNT_WIDTH-1:0] cntInc;

    // prime_q counts the edges until prev_q holds a real sample of pwm_in, so a line
    // that is already high when reset releases is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            prime_q <= 2'd0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (prime_q != 2'd3) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    assign primed  = (prime_q == 2'd3);
    assign rise    = primed & sync2_q & ~prev_q;
    assign fall    = primed & ~sync2_q & prev_q;
    assign level   = sync2_q;
    assign atLimit = (cnt_q >= TIMEOUT_CNT);
    assign cntInc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hiTmp_q    <= '0;
            period_q   <= '0;
            highTime_q <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hiTmp_q    <= hiTmp_d;
            period_q   <= period_d;
            highTime_q <= highTime_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    // An edge arriving in the same cycle the counter hits the limit wins over the timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hiTmp_d    = hiTmp_q;
        period_d   = period_q;
        highTime_d = highTime_q;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = MEAS_HIGH;
                    cnt_d     = CNT_ONE;
                    timeout_d = 1'b0;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    hiTmp_d = cnt_q;
                    cnt_d   = cntInc;
                    state_d = MEAS_LOW;
                end else if (atLimit) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cntInc;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    period_d   = cnt_q;
                    highTime_d = hiTmp_q;
                    valid_d    = 1'b1;
                    cnt_d      = CNT_ONE;
                    state_d    = MEAS_HIGH;
                end else if (atLimit) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cntInc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign period    = period_q;
    assign high_time = highTime_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: one default instance for measurement,
// reset and async-phase checks, one TIMEOUT=100 instance for timeout behaviour.
`timescale 1ns/1ps

module tb_pwm_duty_decoder;

    typedef struct {
        int per;
        int hi;
        int tol;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        pwmA, pwmB;
    logic [15:0] periodA, highA, periodB, highB;
    logic        validA, timeoutA, levelA;
    logic        validB, timeoutB, levelB;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t expA[$];
    exp_t expB[$];
    exp_t monA, monB;

    pwm_duty_decoder #(.CNT_WIDTH(16), .TIMEOUT(65535)) dutA (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwmA),
        .period    (periodA),
        .high_time (highA),
        .valid     (validA),
        .timeout   (timeoutA),
        .level     (levelA)
    );

    pwm_duty_decoder #(.CNT_WIDTH(16), .TIMEOUT(100)) dutB (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwmB),
        .period    (periodB),
        .high_time (highB),
        .valid     (validB),
        .timeout   (timeoutB),
        .level     (levelB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic checkNear(input string tag, input logic [31:0] obs, input logic [31:0] expv,
                             input logic [31:0] tol);
        vectors++;
        assert ((obs + tol >= expv) && (obs <= expv + tol)) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, expv, tol);
        end
    endtask

    task automatic drive(input int which, input logic lvl, input int n);
        if (which == 0) pwmA = lvl;
        else            pwmB = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runPeriod(input int which, input int h, input int l);
        exp_t e;
        e.per = h + l;
        e.hi  = h;
        e.tol = 0;
        if (which == 0) expA.push_back(e);
        else            expB.push_back(e);
        drive(which, 1'b1, h);
        drive(which, 1'b0, l);
    endtask

    // Every valid pulse must match the oldest outstanding expected measurement.
    always @(negedge clk) begin
        if (validA === 1'b1) begin
            if (expA.size() == 0) begin
                checkVal("A unexpected valid", 32'(validA), 32'd0);
            end else begin
                monA = expA.pop_front();
                checkNear("A period", 32'(periodA), monA.per, monA.tol);
                checkNear("A high_time", 32'(highA), monA.hi, monA.tol);
            end
        end
        if (validB === 1'b1) begin
            if (expB.size() == 0) begin
                checkVal("B unexpected valid", 32'(validB), 32'd0);
            end else begin
                monB = expB.pop_front();
                checkNear("B period", 32'(periodB), monB.per, monB.tol);
                checkNear("B high_time", 32'(highB), monB.hi, monB.tol);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        rst  = 1'b1;
        pwmA = 1'b0;
        pwmB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset period", 32'(periodA), 32'd0);
        checkVal("reset high_time", 32'(highA), 32'd0);
        checkVal("reset valid", 32'(validA), 32'd0);
        checkVal("reset timeout", 32'(timeoutA), 32'd0);
        checkVal("reset level", 32'(levelA), 32'd0);
        checkVal("reset B timeout", 32'(timeoutB), 32'd0);
        rst = 1'b0;
        drive(0, 1'b0, 5);

        // Steady 2046/245 waveform, then a duty sweep at the same period.
        for (int i = 0; i < 4; i++) runPeriod(0, 245, 1801);
        runPeriod(0, 1, 2045);
        runPeriod(0, 1023, 1023);
        runPeriod(0, 2045, 1);
        runPeriod(0, 10, 20);

        // Reset in the middle of a high phase discards the partial measurement.
        drive(0, 1'b1, 10);
        checkVal("A level high", 32'(levelA), 32'd1);
        checkVal("A held period", 32'(periodA), 32'd30);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkVal("rst period", 32'(periodA), 32'd0);
        checkVal("rst high_time", 32'(highA), 32'd0);
        checkVal("rst level", 32'(levelA), 32'd0);
        checkVal("rst valid", 32'(validA), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst held period", 32'(periodA), 32'd0);
        checkVal("rst held timeout", 32'(timeoutA), 32'd0);
        rst = 1'b0;
        drive(0, 1'b1, 10);
        drive(0, 1'b0, 30);
        checkVal("post-rst period still 0", 32'(periodA), 32'd0);
        checkVal("post-rst high still 0", 32'(highA), 32'd0);
        runPeriod(0, 20, 30);
        runPeriod(0, 20, 30);

        // Asynchronous 403 ns / 151 ns waveform against the 10 ns clock.
        #($urandom_range(1, 8));
        for (int i = 0; i < 4; i++) begin
            e.per = 40;
            e.hi  = 15;
            e.tol = 1;
            expA.push_back(e);
            pwmA = 1'b1;
            #151;
            pwmA = 1'b0;
            #252;
        end
        pwmA = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 1'b1, 10);
        drive(0, 1'b0, 5);
        checkVal("A scoreboard drained", 32'(expA.size()), 32'd0);

        // TIMEOUT=100 instance: latency, edge-at-limit priority, timeout and recovery.
        runPeriod(1, 30, 70);
        e.per = 100;
        e.hi  = 30;
        e.tol = 0;
        expB.push_back(e);
        pwmB = 1'b1;
        @(posedge clk); #1;
        checkVal("B valid early 1", 32'(validB), 32'd0);
        @(posedge clk); #1;
        checkVal("B valid early 2", 32'(validB), 32'd0);
        @(posedge clk); #1;
        checkVal("B valid latency", 32'(validB), 32'd1);
        checkVal("B timeout at limit edge", 32'(timeoutB), 32'd0);
        @(posedge clk); #1;
        checkVal("B valid width", 32'(validB), 32'd0);
        drive(1, 1'b1, 26);
        drive(1, 1'b0, 70);

        pwmB = 1'b1;
        repeat (102) begin
            @(posedge clk);
            #1;
        end
        checkVal("B timeout before limit", 32'(timeoutB), 32'd0);
        @(posedge clk); #1;
        checkVal("B timeout asserted", 32'(timeoutB), 32'd1);
        checkVal("B period kept", 32'(periodB), 32'd100);
        checkVal("B high_time kept", 32'(highB), 32'd30);
        drive(1, 1'b1, 10);
        checkVal("B timeout level", 32'(timeoutB), 32'd1);
        drive(1, 1'b0, 20);
        checkVal("B timeout after fall", 32'(timeoutB), 32'd1);
        pwmB = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkVal("B timeout before rise", 32'(timeoutB), 32'd1);
        @(posedge clk); #1;
        checkVal("B timeout cleared", 32'(timeoutB), 32'd0);
        expB.push_back(e);
        drive(1, 1'b1, 27);
        drive(1, 1'b0, 70);
        drive(1, 1'b1, 10);
        drive(1, 1'b0, 5);
        checkVal("B scoreboard drained", 32'(expB.size()), 32'd0);
        checkVal("B final period", 32'(periodB), 32'd100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
